// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Groups every bus signal of the memory arbiter: the CPU request port (c_*),
// the host/loader request port (h_*), the single-port memory side (mem_*),
// and the status outputs (owner, state_out).
//   slave  : the arbiter's view (requests and mem_rdata in; acks, read data,
//            memory controls and status out)
//   master : the environment's view (requesters plus memory), the mirror image
interface mem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    // CPU port
    logic          c_req;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic          c_ack;
    logic [DW-1:0] c_rdata;

    // Host/loader port
    logic          h_req;
    logic          h_we;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata;
    logic          h_ack;
    logic [DW-1:0] h_rdata;

    // Memory side (registered-output synchronous RAM)
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Status
    logic          owner;
    logic [1:0]    state_out;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_ack, c_rdata,
        input  h_req, h_we, h_addr, h_wdata,
        output h_ack, h_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output owner, state_out
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_ack, c_rdata,
        output h_req, h_we, h_addr, h_wdata,
        input  h_ack, h_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  owner, state_out
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port synchronous memory between the CPU (port C) and an
// external host/loader (port H). Each access runs IDLE -> ACCESS -> RESP:
// the winner's request is latched in IDLE, the memory is driven from that
// latch in ACCESS, and the owner's one-cycle ack is raised in RESP while the
// registered memory output is presented as read data. Simultaneous requests
// are resolved round-robin.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : mem_arbiter_if.slave -- CPU port, host port, memory side,
//           owner (0 = C, 1 = H) and state_out (IDLE=0, ACCESS=1, RESP=2)
module mem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_reg;
    logic          prio_reg;       // port that wins a tie (0 = C, 1 = H)
    logic          owner_reg;      // port of current/last grant
    logic          lat_we_reg;
    logic [AW-1:0] lat_addr_reg;
    logic [DW-1:0] lat_wdata_reg;

    // Arbitration: a lone requester always wins; prio only breaks ties.
    logic any_req;
    logic grant_h;
    assign any_req = bus.c_req | bus.h_req;
    assign grant_h = bus.h_req & (~bus.c_req | prio_reg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            prio_reg      <= 1'b0;
            owner_reg     <= 1'b0;
            lat_we_reg    <= 1'b0;
            lat_addr_reg  <= '0;
            lat_wdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Requests are only looked at here, so anything the
                    // requester changes later cannot disturb the access.
                    if (any_req) begin
                        owner_reg     <= grant_h;
                        lat_we_reg    <= grant_h ? bus.h_we    : bus.c_we;
                        lat_addr_reg  <= grant_h ? bus.h_addr  : bus.c_addr;
                        lat_wdata_reg <= grant_h ? bus.h_wdata : bus.c_wdata;
                        state_reg     <= ACCESS;
                    end
                end
                ACCESS: begin
                    state_reg <= RESP;
                end
                RESP: begin
                    // Hand the tie-break to whichever port was not served.
                    prio_reg  <= ~owner_reg;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Controls decode from state only, so they drop immediately on reset.
    assign bus.mem_en    = (state_reg == ACCESS);
    assign bus.mem_we    = (state_reg == ACCESS) & lat_we_reg;
    assign bus.mem_addr  = lat_addr_reg;
    assign bus.mem_wdata = lat_wdata_reg;

    assign bus.c_ack     = (state_reg == RESP) & ~owner_reg;
    assign bus.h_ack     = (state_reg == RESP) &  owner_reg;

    // Both ports mirror the memory output; only the owner's ack qualifies it.
    assign bus.c_rdata   = bus.mem_rdata;
    assign bus.h_rdata   = bus.mem_rdata;

    assign bus.owner     = owner_reg;
    assign bus.state_out = state_reg;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter: a registered-output RAM model sits on the
// memory side, and a linear sequence of steps checks reset behaviour, reads,
// writes, request latching, round-robin conflicts and saturation.
module tb_mem_arbiter;
    localparam int AW = 8;
    localparam int DW = 16;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM with registered read data.
    logic [DW-1:0] mem_array [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we)
                mem_array[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= mem_array[bus.mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    int ack_count;
    logic exp_c;
    logic exp_h;

    initial begin
        reset = 1'b1;
        bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_wdata = '0;
        bus.h_req = 1'b0; bus.h_we = 1'b0; bus.h_addr = '0; bus.h_wdata = '0;
        bus.mem_rdata = '0;

        // Reset state
        step();
        step();
        chk("rst_state",  bus.state_out, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_addr",   bus.mem_addr, 0);
        chk("rst_wdata",  bus.mem_wdata, 0);
        chk("rst_c_ack",  bus.c_ack, 0);
        chk("rst_h_ack",  bus.h_ack, 0);
        chk("rst_owner",  bus.owner, 0);
        $display("txn reset: state=%0d mem_en=%0d", bus.state_out, bus.mem_en);
        reset = 1'b0;

        // Host write 0x1234 -> 0x05 (lone host, prio = C)
        bus.h_req = 1'b1; bus.h_we = 1'b1; bus.h_addr = 8'h05; bus.h_wdata = 16'h1234;
        step();
        chk("hw1_state",  bus.state_out, 1);
        chk("hw1_mem_en", bus.mem_en, 1);
        chk("hw1_mem_we", bus.mem_we, 1);
        chk("hw1_addr",   bus.mem_addr, 8'h05);
        chk("hw1_wdata",  bus.mem_wdata, 16'h1234);
        chk("hw1_owner",  bus.owner, 1);
        step();
        chk("hw1_state2", bus.state_out, 2);
        chk("hw1_h_ack",  bus.h_ack, 1);
        chk("hw1_c_ack",  bus.c_ack, 0);
        chk("hw1_en_off", bus.mem_en, 0);
        $display("txn host write addr=05 data=1234 h_ack=%0d", bus.h_ack);
        bus.h_req = 1'b0; bus.h_we = 1'b0;
        step();
        chk("hw1_idle",   bus.state_out, 0);
        chk("hw1_ack_off", bus.h_ack, 0);

        // CPU read of 0x05, aborted by reset during ACCESS
        bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 8'h05;
        step();
        chk("ab_state",   bus.state_out, 1);
        chk("ab_mem_en",  bus.mem_en, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("ab_rst_state", bus.state_out, 0);
        chk("ab_rst_en",    bus.mem_en, 0);
        chk("ab_rst_c_ack", bus.c_ack, 0);
        chk("ab_rst_h_ack", bus.h_ack, 0);
        chk("ab_rst_addr",  bus.mem_addr, 0);
        $display("txn reset during ACCESS: state=%0d mem_en=%0d", bus.state_out, bus.mem_en);
        step();
        reset = 1'b0;

        // Re-arbitration after release; c_addr changes during ACCESS
        step();
        chk("cr_state",   bus.state_out, 1);
        chk("cr_mem_en",  bus.mem_en, 1);
        chk("cr_mem_we",  bus.mem_we, 0);
        chk("cr_addr",    bus.mem_addr, 8'h05);
        chk("cr_h_ack",   bus.h_ack, 0);
        bus.c_addr = 8'h06;
        #1;
        chk("cr_addr_hold", bus.mem_addr, 8'h05);
        step();
        chk("cr_c_ack",   bus.c_ack, 1);
        chk("cr_h_ack2",  bus.h_ack, 0);
        chk("cr_rdata",   bus.c_rdata, 16'h1234);
        chk("cr_addr_rsp", bus.mem_addr, 8'h05);
        $display("txn cpu read addr=05 rdata=%h c_ack=%0d", bus.c_rdata, bus.c_ack);
        bus.c_req = 1'b0;
        step();
        chk("cr_idle",    bus.state_out, 0);
        chk("cr_ack_off", bus.c_ack, 0);

        // Host write 0x00AB -> 0x10, then CPU read of 0x10
        bus.h_req = 1'b1; bus.h_we = 1'b1; bus.h_addr = 8'h10; bus.h_wdata = 16'h00AB;
        step();
        chk("hw2_mem_we", bus.mem_we, 1);
        chk("hw2_addr",   bus.mem_addr, 8'h10);
        chk("hw2_owner",  bus.owner, 1);
        step();
        chk("hw2_h_ack",  bus.h_ack, 1);
        chk("hw2_c_ack",  bus.c_ack, 0);
        $display("txn host write addr=10 data=00ab h_ack=%0d", bus.h_ack);
        bus.h_req = 1'b0; bus.h_we = 1'b0;
        step();
        bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 8'h10;
        step();
        chk("cr2_owner",  bus.owner, 0);
        chk("cr2_mem_we", bus.mem_we, 0);
        step();
        chk("cr2_c_ack",  bus.c_ack, 1);
        chk("cr2_rdata",  bus.c_rdata, 16'h00AB);
        $display("txn cpu read addr=10 rdata=%h c_ack=%0d", bus.c_rdata, bus.c_ack);
        bus.c_req = 1'b0;
        step();

        // Conflict right after reset: C first (ack T+2), H at T+5
        reset_pulse();
        bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 8'h05;
        bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_addr = 8'h10;
        step();
        chk("cf_owner1",  bus.owner, 0);
        chk("cf_addr1",   bus.mem_addr, 8'h05);
        step();
        chk("cf_c_ack",   bus.c_ack, 1);
        chk("cf_h_ack0",  bus.h_ack, 0);
        chk("cf_c_rdata", bus.c_rdata, 16'h1234);
        $display("txn conflict: cpu acked rdata=%h", bus.c_rdata);
        bus.c_req = 1'b0;
        step();
        chk("cf_h_wait",  bus.h_ack, 0);
        step();
        chk("cf_owner2",  bus.owner, 1);
        chk("cf_addr2",   bus.mem_addr, 8'h10);
        step();
        chk("cf_h_ack",   bus.h_ack, 1);
        chk("cf_c_ack0",  bus.c_ack, 0);
        chk("cf_h_rdata", bus.h_rdata, 16'h00AB);
        $display("txn conflict: host acked rdata=%h", bus.h_rdata);
        bus.h_req = 1'b0;
        step();

        // Lone CPU access hands priority to H; the next pair serves H first
        bus.c_req = 1'b1;
        step();
        step();
        chk("lc_c_ack",   bus.c_ack, 1);
        $display("txn lone cpu read c_ack=%0d", bus.c_ack);
        bus.c_req = 1'b0;
        step();
        bus.c_req = 1'b1; bus.h_req = 1'b1;
        step();
        chk("pr_owner1",  bus.owner, 1);
        step();
        chk("pr_h_ack",   bus.h_ack, 1);
        chk("pr_c_ack0",  bus.c_ack, 0);
        $display("txn pair: host acked first");
        bus.h_req = 1'b0;
        step();
        step();
        chk("pr_owner2",  bus.owner, 0);
        step();
        chk("pr_c_ack",   bus.c_ack, 1);
        $display("txn pair: cpu acked second");
        bus.c_req = 1'b0;
        step();

        // Saturation: both requesting for 24 cycles after reset
        reset_pulse();
        ack_count = 0;
        bus.c_req = 1'b1; bus.h_req = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            step();
            exp_c = (i % 3 == 2) && ((i / 3) % 2 == 0);
            exp_h = (i % 3 == 2) && ((i / 3) % 2 == 1);
            chk($sformatf("sat_c_ack_%0d", i), bus.c_ack, exp_c);
            chk($sformatf("sat_h_ack_%0d", i), bus.h_ack, exp_h);
            if (bus.c_ack || bus.h_ack) begin
                ack_count++;
                $display("txn saturation cycle=%0d c_ack=%0d h_ack=%0d", i, bus.c_ack, bus.h_ack);
            end
        end
        chk("sat_ack_count", ack_count, 8);
        bus.c_req = 1'b0; bus.h_req = 1'b0;
        step();
        step();
        step();
        chk("end_idle", bus.state_out, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
